// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 encodings, LSU state enum and the store strobe helper
// shared by the data-memory load/store unit.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } lsu_state_e;

   function automatic logic [3:0] st_strb(
      input logic [2:0] f3,
      input logic [1:0] off
   );
      logic [3:0] s;
      case (f3)
         F3_B, F3_BU: s = 4'b0001 << off;
         F3_H, F3_HU: s = 4'b0011 << {off[1], 1'b0};
         default:     s = 4'b1111;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// dmem_lsu_align: store lane/strobe generation and load byte/half
// extraction with sign or zero extension.
module dmem_lsu_align
   import dmem_pkg::*;
(
   input  logic        st_en_i,
   input  logic [2:0]  st_f3_i,
   input  logic [1:0]  st_off_i,
   input  logic [31:0] st_data_i,
   output logic [3:0]  st_strb_o,
   output logic [31:0] st_data_o,
   input  logic [2:0]  ld_f3_i,
   input  logic [1:0]  ld_off_i,
   input  logic [31:0] ld_data_i,
   output logic [31:0] ld_data_o
);

   logic [7:0]  b8;
   logic [15:0] h16;

   assign b8  = ld_data_i[{ld_off_i, 3'b000} +: 8];
   assign h16 = ld_data_i[{ld_off_i[1], 4'b0000} +: 16];

   assign st_strb_o = st_en_i ? st_strb(st_f3_i, st_off_i) : 4'b0000;

   // Replicating into every lane lets the strobes alone pick the bytes.
   always_comb begin
      st_data_o = '0;
      if (st_en_i) begin
         case (st_f3_i)
            F3_B, F3_BU: st_data_o = {4{st_data_i[7:0]}};
            F3_H, F3_HU: st_data_o = {2{st_data_i[15:0]}};
            default:     st_data_o = st_data_i;
         endcase
      end
   end

   always_comb begin
      ld_data_o = ld_data_i;
      case (ld_f3_i)
         F3_B:    ld_data_o = {{24{b8[7]}}, b8};
         F3_BU:   ld_data_o = {24'h0, b8};
         F3_H:    ld_data_o = {{16{h16[15]}}, h16};
         F3_HU:   ld_data_o = {16'h0, h16};
         default: ld_data_o = ld_data_i;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding load/store unit in front of the data bus.
// Alignment checking is compiled in with DMEM_LSU_ALIGN_CHECK_EN.
module dmem_lsu
   import dmem_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_load_i,
   input  logic        req_store_i,
   input  logic        req_lr_i,
   input  logic        req_sc_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_data_o,
   output logic        rsp_err_o,
   output logic        bus_re_o,
   output logic        bus_we_o,
   output logic        bus_lr_o,
   output logic        bus_sc_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_wstrb_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_stall_i
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST =
      CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   lsu_state_e  state_q, state_d;
   logic        ld_q, ld_d;
   logic        sc_q, sc_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic        seen_q, seen_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        re_q, re_d, we_q, we_d;
   logic        lr_q, lr_d, bsc_q, bsc_d;
   logic [31:0] baddr_q, baddr_d;
   logic [31:0] bwdata_q, bwdata_d;
   logic [3:0]  bstrb_q, bstrb_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [2:0]  f3_in;
   logic        misal, bad, accept;
   logic [3:0]  strb_w;
   logic [31:0] wdata_w, ldata_w;

   assign req_ready_o = (state_q == IDLE) && !bus_stall_i;
   assign accept = req_valid_i && req_ready_o;
   assign f3_in = (req_lr_i || req_sc_i) ? F3_W : req_funct3_i;

`ifdef DMEM_LSU_ALIGN_CHECK_EN
   assign misal =
      ((f3_in == F3_H || f3_in == F3_HU) && req_addr_i[0]) ||
      (f3_in == F3_W && req_addr_i[1:0] != 2'b00);
`else
   assign misal = 1'b0;
`endif

   // Address 0 means "no request" on the bus, so it can never be issued.
   assign bad = (req_addr_i == 32'h0) || misal;

   dmem_lsu_align u_align (
      .st_en_i   (req_store_i),
      .st_f3_i   (f3_in),
      .st_off_i  (req_addr_i[1:0]),
      .st_data_i (req_wdata_i),
      .st_strb_o (strb_w),
      .st_data_o (wdata_w),
      .ld_f3_i   (f3_q),
      .ld_off_i  (off_q),
      .ld_data_i (bus_rdata_i),
      .ld_data_o (ldata_w)
   );

   always_comb begin
      state_d  = state_q;
      ld_d     = ld_q;
      sc_d     = sc_q;
      f3_d     = f3_q;
      off_d    = off_q;
      seen_d   = seen_q;
      cnt_d    = cnt_q;
      re_d     = 1'b0;
      we_d     = 1'b0;
      lr_d     = 1'b0;
      bsc_d    = 1'b0;
      baddr_d  = '0;
      bwdata_d = '0;
      bstrb_d  = '0;
      rdata_d  = '0;
      err_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               ld_d  = req_load_i;
               sc_d  = req_sc_i;
               f3_d  = f3_in;
               off_d = req_addr_i[1:0];
               if (bad) begin
                  state_d = RESP;
                  err_d   = 1'b1;
               end else begin
                  state_d  = ISSUE;
                  re_d     = req_load_i;
                  we_d     = req_store_i;
                  lr_d     = req_lr_i;
                  bsc_d    = req_sc_i;
                  baddr_d  = {req_addr_i[31:2], 2'b00};
                  bwdata_d = wdata_w;
                  bstrb_d  = strb_w;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
            seen_d  = 1'b0;
            cnt_d   = '0;
         end
         WAIT: begin
            seen_d = seen_q || bus_stall_i;
            // The bus stall is registered; wait for it to rise then fall.
            if (seen_q && !bus_stall_i) begin
               state_d = RESP;
               if (sc_q)
                  rdata_d = {31'h0, bus_rdata_i[0]};
               else if (ld_q)
                  rdata_d = ldata_w;
            end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
               state_d = RESP;
               err_d   = 1'b1;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         ld_q     <= 1'b0;
         sc_q     <= 1'b0;
         f3_q     <= '0;
         off_q    <= '0;
         seen_q   <= 1'b0;
         cnt_q    <= '0;
         re_q     <= 1'b0;
         we_q     <= 1'b0;
         lr_q     <= 1'b0;
         bsc_q    <= 1'b0;
         baddr_q  <= '0;
         bwdata_q <= '0;
         bstrb_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ld_q     <= ld_d;
         sc_q     <= sc_d;
         f3_q     <= f3_d;
         off_q    <= off_d;
         seen_q   <= seen_d;
         cnt_q    <= cnt_d;
         re_q     <= re_d;
         we_q     <= we_d;
         lr_q     <= lr_d;
         bsc_q    <= bsc_d;
         baddr_q  <= baddr_d;
         bwdata_q <= bwdata_d;
         bstrb_q  <= bstrb_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign rsp_valid_o = (state_q == RESP);
   assign rsp_data_o  = rdata_q;
   assign rsp_err_o   = err_q;
   assign bus_re_o    = re_q;
   assign bus_we_o    = we_q;
   assign bus_lr_o    = lr_q;
   assign bus_sc_o    = bsc_q;
   assign bus_addr_o  = baddr_q;
   assign bus_wdata_o = bwdata_q;
   assign bus_wstrb_o = bstrb_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed and randomized operations against a byte-level
// reference model of the load/store unit.
module tb_dmem_lsu;
   import dmem_pkg::*;

   localparam int TO = 8;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_load_i = 1'b0;
   logic        req_store_i = 1'b0;
   logic        req_lr_i = 1'b0;
   logic        req_sc_i = 1'b0;
   logic [2:0]  req_funct3_i = '0;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic        rsp_valid_o;
   logic [31:0] rsp_data_o;
   logic        rsp_err_o;
   logic        bus_re_o, bus_we_o, bus_lr_o, bus_sc_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_wstrb_o;
   logic [31:0] bus_rdata_i = '0;
   logic        bus_stall_i = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   dmem_lsu #(.TIMEOUT(TO)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_load_i   (req_load_i),
      .req_store_i  (req_store_i),
      .req_lr_i     (req_lr_i),
      .req_sc_i     (req_sc_i),
      .req_funct3_i (req_funct3_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_data_o   (rsp_data_o),
      .rsp_err_o    (rsp_err_o),
      .bus_re_o     (bus_re_o),
      .bus_we_o     (bus_we_o),
      .bus_lr_o     (bus_lr_o),
      .bus_sc_o     (bus_sc_o),
      .bus_addr_o   (bus_addr_o),
      .bus_wdata_o  (bus_wdata_o),
      .bus_wstrb_o  (bus_wstrb_o),
      .bus_rdata_i  (bus_rdata_i),
      .bus_stall_i  (bus_stall_i)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int sz_of(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: return 1;
         F3_H, F3_HU: return 2;
         default:     return 4;
      endcase
   endfunction

   function automatic logic m_err(input logic [2:0] f3,
                                  input logic [31:0] a);
      logic e;
      e = (a == 32'h0);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
      e = e || ((a % sz_of(f3)) != 0);
`endif
      return e;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3,
                                          input logic [1:0] off,
                                          input logic [31:0] rd);
      longint sz, base, v;
      sz = sz_of(f3);
      base = (longint'(off) / sz) * sz;
      v = (longint'(rd) >> (8 * base)) & ((64'sd1 << (8 * sz)) - 1);
      if ((f3 == F3_B || f3 == F3_H) && v >= (64'sd1 << (8 * sz - 1)))
         v = v - (64'sd1 << (8 * sz));
      return v[31:0];
   endfunction

   function automatic logic [3:0] m_strb(input logic [2:0] f3,
                                         input logic [1:0] off);
      int sz, base;
      sz = sz_of(f3);
      base = (int'(off) / sz) * sz;
      return 4'(((1 << sz) - 1) << base);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                           input logic [31:0] d);
      logic [31:0] w;
      int sz;
      sz = sz_of(f3);
      for (int b = 0; b < 4; b++)
         w[8*b +: 8] = d[8*(b % sz) +: 8];
      return w;
   endfunction

   task automatic do_op(input string nm, input logic ld, input logic st,
                        input logic lr, input logic sc,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int pre, input int nst,
                        output logic [31:0] got);
      logic [2:0]  ef3;
      logic [31:0] exp;
      ef3 = (lr || sc) ? F3_W : f3;
      if (sc)      exp = {31'h0, rd[0]};
      else if (ld) exp = m_load(ef3, addr[1:0], rd);
      else         exp = 32'h0;
      @(posedge clk_i); #1;
      req_valid_i = 1'b1; req_load_i = ld; req_store_i = st;
      req_lr_i = lr; req_sc_i = sc; req_funct3_i = f3;
      req_addr_i = addr; req_wdata_i = wd;
      @(negedge clk_i);
      chk({nm, ".rdy"}, req_ready_o, 1'b1);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      @(negedge clk_i);
      if (m_err(ef3, addr)) begin
         chk({nm, ".evld"}, rsp_valid_o, 1'b1);
         chk({nm, ".eerr"}, rsp_err_o, 1'b1);
         chk({nm, ".edat"}, rsp_data_o, 32'h0);
         chk({nm, ".ebus"}, {bus_re_o, bus_we_o, bus_addr_o != 0}, 3'b0);
         got = rsp_data_o;
         return;
      end
      chk({nm, ".ivld"}, rsp_valid_o, 1'b0);
      chk({nm, ".addr"}, bus_addr_o, addr & 32'hFFFF_FFFC);
      chk({nm, ".flg"}, {bus_re_o, bus_we_o, bus_lr_o, bus_sc_o},
          {ld, st, lr, sc});
      chk({nm, ".strb"}, bus_wstrb_o, st ? m_strb(ef3, addr[1:0]) : 4'h0);
      chk({nm, ".wdat"}, bus_wdata_o, st ? m_wdata(ef3, wd) : 32'h0);
      for (int c = 0; c < pre + nst + 1; c++) begin
         @(posedge clk_i); #1;
         bus_stall_i = (c >= pre) && (c < pre + nst);
         bus_rdata_i = bus_stall_i ? $urandom : rd;
         @(negedge clk_i);
         chk({nm, ".wvld"}, rsp_valid_o, 1'b0);
         chk({nm, ".wbus"}, bus_addr_o, 32'h0);
      end
      @(posedge clk_i); #1;
      bus_rdata_i = $urandom;
      @(negedge clk_i);
      chk({nm, ".vld"}, rsp_valid_o, 1'b1);
      chk({nm, ".err"}, rsp_err_o, 1'b0);
      chk({nm, ".dat"}, rsp_data_o, exp);
      got = rsp_data_o;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk({nm, ".done"}, {rsp_valid_o, req_ready_o}, 2'b01);
   endtask

   task automatic rst_mid(input string nm, input int at);
      @(posedge clk_i); #1;
      req_valid_i = 1'b1; req_load_i = 1'b0; req_store_i = 1'b1;
      req_lr_i = 1'b0; req_sc_i = 1'b0; req_funct3_i = F3_W;
      req_addr_i = 32'h400; req_wdata_i = 32'hCAFE_F00D;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      for (int c = 1; c < at; c++) begin
         @(posedge clk_i); #1;
         bus_stall_i = 1'b1;
      end
      #2;
      if (at == 1) chk({nm, ".pre"}, bus_we_o, 1'b1);
      bus_stall_i = 1'b1;
      rst_ni = 1'b0;
      #1;
      chk({nm, ".bus"}, {bus_re_o, bus_we_o, bus_lr_o, bus_sc_o,
          bus_wstrb_o != 0, bus_wdata_o != 0, bus_addr_o != 0}, 7'b0);
      chk({nm, ".rsp"}, {rsp_valid_o, rsp_err_o, rsp_data_o != 0}, 3'b0);
      chk({nm, ".rdy0"}, req_ready_o, 1'b0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      req_valid_i = 1'b1; req_store_i = 1'b0; req_load_i = 1'b1;
      req_addr_i = 32'h500;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         chk({nm, ".drain"}, {req_ready_o, rsp_valid_o, bus_re_o}, 3'b0);
         @(posedge clk_i); #1;
      end
      bus_stall_i = 1'b0;
      req_valid_i = 1'b0;
      @(negedge clk_i);
      chk({nm, ".rdy1"}, {req_ready_o, rsp_valid_o}, 2'b10);
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] a, wd, rd;
      int k;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst.rsp", {rsp_valid_o, rsp_err_o, rsp_data_o != 0}, 3'b0);
      chk("rst.bus", {bus_re_o, bus_we_o, bus_lr_o, bus_sc_o,
          bus_wstrb_o != 0, bus_wdata_o != 0, bus_addr_o != 0}, 7'b0);
      chk("rst.rdy", req_ready_o, 1'b1);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      do_op("lw", 1, 0, 0, 0, F3_W, 32'h100, 0, 32'hDEAD_BEEF, 0, 3, got);
      chk("lw.k", got, 32'hDEAD_BEEF);
      do_op("lb", 1, 0, 0, 0, F3_B, 32'h103, 0, 32'h80AB_CDEF, 0, 3, got);
      chk("lb.k", got, 32'hFFFF_FF80);
      do_op("lbu", 1, 0, 0, 0, F3_BU, 32'h103, 0, 32'h80AB_CDEF, 0, 3, got);
      chk("lbu.k", got, 32'h0000_0080);
      do_op("sh", 0, 1, 0, 0, F3_H, 32'h102, 32'h1234, 32'h0, 0, 3, got);
      chk("sh.k", got, 32'h0);
      do_op("sc", 0, 1, 0, 1, F3_W, 32'h200, 32'h77, 32'h1, 0, 3, got);
      chk("sc.k", got, 32'h1);
      do_op("lr", 1, 0, 1, 0, F3_W, 32'h200, 0, 32'h5555_AAAA, 0, 3, got);
      chk("lr.k", got, 32'h5555_AAAA);
      do_op("lw0", 1, 0, 0, 0, F3_W, 32'h0, 0, 32'h1, 0, 3, got);
      do_op("lhmis", 1, 0, 0, 0, F3_H, 32'h101, 0, 32'h9876_5432, 0, 3, got);
      do_op("late", 1, 0, 0, 0, F3_HU, 32'h302, 0, 32'hF00F_1234, 1, 3, got);
      do_op("cont", 1, 0, 0, 0, F3_H, 32'h306, 0, 32'h8001_7FFF, 0, 6, got);

      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 9);
         a = {20'h0, 12'($urandom_range(4, 4095))};
         if ($urandom_range(0, 15) == 0) a = 32'h0;
         wd = $urandom;
         rd = $urandom;
         case (k)
            0: do_op("r.lb", 1, 0, 0, 0, F3_B, a, wd, rd,
                     $urandom_range(0, 1), $urandom_range(1, 4), got);
            1: do_op("r.lh", 1, 0, 0, 0, F3_H, a, wd, rd,
                     $urandom_range(0, 1), $urandom_range(1, 4), got);
            2: do_op("r.lw", 1, 0, 0, 0, F3_W, a, wd, rd,
                     $urandom_range(0, 1), $urandom_range(1, 4), got);
            3: do_op("r.lbu", 1, 0, 0, 0, F3_BU, a, wd, rd,
                     $urandom_range(0, 1), $urandom_range(1, 4), got);
            4: do_op("r.lhu", 1, 0, 0, 0, F3_HU, a, wd, rd,
                     $urandom_range(0, 1), $urandom_range(1, 4), got);
            5: do_op("r.sb", 0, 1, 0, 0, F3_B, a, wd, rd,
                     $urandom_range(0, 1), $urandom_range(1, 4), got);
            6: do_op("r.sh", 0, 1, 0, 0, F3_H, a, wd, rd,
                     $urandom_range(0, 1), $urandom_range(1, 4), got);
            7: do_op("r.sw", 0, 1, 0, 0, F3_W, a, wd, rd,
                     $urandom_range(0, 1), $urandom_range(1, 4), got);
            8: do_op("r.lr", 1, 0, 1, 0, F3_W, a, wd, rd,
                     $urandom_range(0, 1), $urandom_range(1, 4), got);
            default: do_op("r.sc", 0, 1, 0, 1, F3_W, a, wd, rd,
                     $urandom_range(0, 1), $urandom_range(1, 4), got);
         endcase
      end

      // Bus never releases: the unit gives up after TO wait cycles.
      @(posedge clk_i); #1;
      req_valid_i = 1'b1; req_load_i = 1'b1; req_store_i = 1'b0;
      req_lr_i = 1'b0; req_sc_i = 1'b0; req_funct3_i = F3_W;
      req_addr_i = 32'h600;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      for (int c = 2; c < 22; c++) begin
         @(posedge clk_i); #1;
         bus_stall_i = 1'b1;
         bus_rdata_i = $urandom;
         @(negedge clk_i);
         chk("to.vld", rsp_valid_o, c == 2 + TO);
         chk("to.rdy", req_ready_o, 1'b0);
         if (rsp_valid_o)
            chk("to.err", {rsp_err_o, rsp_data_o != 0}, 2'b10);
      end
      @(posedge clk_i); #1;
      bus_stall_i = 1'b0;
      @(negedge clk_i);
      chk("to.rdy1", req_ready_o, 1'b1);

      rst_mid("rsti", 1);
      rst_mid("rstw", 3);
      do_op("post", 1, 0, 0, 0, F3_W, 32'h700, 0, 32'h0BAD_F00D, 0, 3, got);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
